// File: rtl/gen_cla_decomposed_block_if.sv
// Operand/sum bundle for the decomposed carry-lookahead adder.
// The master drives the operands and the slave returns the registered sum.
interface gen_cla_decomposed_block_if #(
   parameter int NBIT = 16
);
   logic [NBIT-1:0] a;
   logic [NBIT-1:0] b;
   logic [NBIT-1:0] s;

   modport master (output a, output b, input s);
   modport slave  (input a, input b, output s);
endinterface

// File: rtl/gen_cla_decomposed_block.sv
// Registered NBIT-bit adder. Every carry is formed directly from generate/propagate
// terms, with no ripple from the carry below it.
module gen_cla_decomposed_block #(
   parameter int NBIT = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   gen_cla_decomposed_block_if.slave  bus
);
   // The top-bit generate would only feed the carry-out, which is dropped.
   logic [NBIT-2:0] g;
   logic [NBIT-1:0] p;
   logic [NBIT-1:0] c;
   logic [NBIT-1:0] s_next;

   assign g = bus.a[NBIT-2:0] & bus.b[NBIT-2:0];
   assign p = bus.a ^ bus.b;
   assign c[0] = 1'b0;

   genvar i, j;
   generate
      for (i = 1; i < NBIT; i++) begin : g_carry
         logic [i-1:0] term;
         for (j = 0; j < i; j++) begin : g_term
            if (j == i - 1) begin : g_direct
               assign term[j] = g[j];
            end else begin : g_prop
               assign term[j] = g[j] & (&p[i-1:j+1]);
            end
         end
         // The product terms are mutually exclusive, so XOR merges them exactly as OR would.
         assign c[i] = ^term;
      end
   endgenerate

   assign s_next = p ^ c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.s <= '0;
      end else begin
         bus.s <= s_next;
      end
   end
endmodule

// File: tb/tb_gen_cla_decomposed_block.sv
// Scoreboard bench for the decomposed CLA adder: a 16-bit and an 8-bit instance are
// driven in lockstep, and the expected sums are queued as the operands are applied.
module tb_gen_cla_decomposed_block;
   logic clk;
   logic rst_n;

   gen_cla_decomposed_block_if #(.NBIT(16)) if16 ();
   gen_cla_decomposed_block_if #(.NBIT(8))  if8 ();

   gen_cla_decomposed_block #(.NBIT(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
   gen_cla_decomposed_block #(.NBIT(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total    = 0;

   logic [15:0] q16[$];
   logic [7:0]  q8[$];

   // Applies one operand pair to both instances and queues the expected sums.
   // Returns 1 ns after the loading edge.
   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp16);
      logic [7:0] a8;
      logic [7:0] b8;
      logic [7:0] exp8;
      @(negedge clk);
      a8 = a[7:0];
      b8 = b[7:0];
      exp8 = a8 + b8;
      if16.a = a;
      if16.b = b;
      if8.a  = a8;
      if8.b  = b8;
      q16.push_back(exp16);
      q8.push_back(exp8);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] e16;
      logic [7:0]  e8;
      rst_n = 1'b0;
      if16.a = 16'h1234;
      if16.b = 16'h4321;
      if8.a  = 8'h12;
      if8.b  = 8'h43;
      #2;
      total++;
      if (if16.s !== 16'h0000) $display("FAIL reset_async16 s=%h expected=0000", if16.s);
      else pass_cnt++;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (if16.s !== 16'h0000 || if8.s !== 8'h00)
         $display("FAIL reset_hold s16=%h s8=%h expected=0", if16.s, if8.s);
      else pass_cnt++;
      if16.a = '0;
      if16.b = '0;
      if8.a  = '0;
      if8.b  = '0;
      #1 rst_n = 1'b1;
      drive(16'd0, 16'd0, 16'd0);
      e16 = q16.pop_front();
      e8  = q8.pop_front();
      total++;
      if (if16.s !== e16 || if8.s !== e8)
         $display("FAIL reset_release s16=%h s8=%h expected %h/%h", if16.s, if8.s, e16, e8);
      else pass_cnt++;
   endtask

   task automatic test_sequence();
      logic [15:0] ta[6] = '{16'd2, 16'd2, 16'd124, 16'd124, 16'd54, 16'd54};
      logic [15:0] tb[6] = '{16'd0, 16'd3, 16'd3,   16'd15,  16'd3,  16'd43};
      logic [15:0] te[6] = '{16'd2, 16'd5, 16'd127, 16'd139, 16'd57, 16'd97};
      logic [15:0] e16;
      logic [7:0]  e8;
      for (int k = 0; k < 6; k++) begin
         drive(ta[k], tb[k], te[k]);
         e16 = q16.pop_front();
         e8  = q8.pop_front();
         total++;
         if (if16.s !== e16 || if8.s !== e8)
            $display("FAIL seq_%0d s16=%0d s8=%0d expected %0d/%0d", k, if16.s, if8.s, e16, e8);
         else pass_cnt++;
      end
   endtask

   task automatic test_wrap_and_chain();
      logic [15:0] ta[4] = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'hAAAA};
      logic [15:0] tb[4] = '{16'h0001, 16'h8000, 16'h0001, 16'h5555};
      logic [15:0] te[4] = '{16'h0000, 16'h0000, 16'h8000, 16'hFFFF};
      logic [15:0] e16;
      logic [7:0]  e8;
      for (int k = 0; k < 4; k++) begin
         drive(ta[k], tb[k], te[k]);
         e16 = q16.pop_front();
         e8  = q8.pop_front();
         total++;
         if (if16.s !== e16 || if8.s !== e8)
            $display("FAIL wrap_chain_%0d s16=%h s8=%h expected %h/%h", k, if16.s, if8.s, e16, e8);
         else pass_cnt++;
      end
   endtask

   task automatic test_async_reset();
      logic [15:0] e16;
      logic [7:0]  e8;
      drive(16'd124, 16'd15, 16'd139);
      e16 = q16.pop_front();
      e8  = q8.pop_front();
      total++;
      if (if16.s !== e16 || if8.s !== e8)
         $display("FAIL pre_reset s16=%0d s8=%0d expected %0d/%0d", if16.s, if8.s, e16, e8);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (if16.s !== 16'h0000 || if8.s !== 8'h00)
         $display("FAIL midcycle_reset s16=%h s8=%h expected=0", if16.s, if8.s);
      else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if16.a = 16'hF0F0;
         if16.b = 16'h0F0F;
         if8.a  = 8'hF0;
         if8.b  = 8'h0F;
         @(posedge clk);
         #1;
         total++;
         if (if16.s !== 16'h0000 || if8.s !== 8'h00)
            $display("FAIL reset_hold_%0d s16=%h s8=%h expected=0", k, if16.s, if8.s);
         else pass_cnt++;
      end
      #1 rst_n = 1'b1;
      drive(16'd54, 16'd43, 16'd97);
      e16 = q16.pop_front();
      e8  = q8.pop_front();
      total++;
      if (if16.s !== e16 || if8.s !== e8)
         $display("FAIL post_reset s16=%0d s8=%0d expected %0d/%0d", if16.s, if8.s, e16, e8);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] e16;
      logic [7:0]  e8;
      int errs = 0;
      for (int k = 0; k < 10000; k++) begin
         a = 16'($urandom_range(0, 65535));
         b = 16'($urandom_range(0, 65535));
         if (k < 16) begin
            a = (k[0]) ? 16'hFFFF : 16'h00FF;
            b = 16'(k);
         end
         drive(a, b, a + b);
         e16 = q16.pop_front();
         e8  = q8.pop_front();
         total++;
         if (if16.s !== e16) begin
            if (errs < 10) $display("FAIL rand16_%0d a=%h b=%h s=%h expected=%h", k, a, b, if16.s, e16);
            errs++;
         end else pass_cnt++;
         total++;
         if (if8.s !== e8) begin
            if (errs < 10) $display("FAIL rand8_%0d a=%h b=%h s=%h expected=%h", k, a[7:0], b[7:0], if8.s, e8);
            errs++;
         end else pass_cnt++;
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      if16.a = '0;
      if16.b = '0;
      if8.a  = '0;
      if8.b  = '0;
      test_reset();
      test_sequence();
      test_wrap_and_chain();
      test_async_reset();
      test_random();
      total++;
      if (q16.size() != 0 || q8.size() != 0)
         $display("FAIL scoreboard_drain left16=%0d left8=%0d expected=0", q16.size(), q8.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
